genome_search_scheduler: RTL and testbench

//  Sequences an off-target search over a genome region. It splits the region into fixed-size chunks and

---
 rtl/genome_search_scheduler.sv | 175 +++++++++++++++++
 tb/tb_genome_search_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/genome_search_scheduler.sv
// genome_search_scheduler: splits a genome region into fixed-size chunks and
// issues one tagged fetch request per chunk to a free comparator engine.
// Tracks engine occupancy, counts completed chunks and reports run status.

// One comparator engine's occupancy bit. A fetch grant reserves it, and a done pulse releases it.
module gss_engine_slot (
  input  logic ACLK,
  input  logic ARESET,
  input  logic reserve,
  input  logic done,
  output logic busy,
  output logic retire,
  output logic spurious
);
  assign retire   = done & busy;
  assign spurious = done & ~busy;

  // Reserve only ever targets a free slot, so set and clear never collide.
  always_ff @(posedge ACLK) begin
    if (ARESET) busy <= 1'b0;
    else        busy <= (busy & ~done) | reserve;
  end
endmodule

module genome_search_scheduler #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 32,
  parameter int CHUNK_BYTES = 64,
  parameter int NUM_ENGINES = 4,
  localparam int TAG_W      = $clog2(NUM_ENGINES)
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   cfg_start,
  input  logic                   cfg_abort,
  input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
  input  logic [LEN_WIDTH-1:0]   cfg_num_chunks,
  output logic                   fetch_req_valid,
  input  logic                   fetch_req_ready,
  output logic [ADDR_WIDTH-1:0]  fetch_req_addr,
  output logic [TAG_W-1:0]       fetch_req_tag,
  input  logic [NUM_ENGINES-1:0] eng_done,
  output logic                   status_busy,
  output logic                   status_done,
  output logic                   status_aborted,
  output logic                   status_error,
  output logic [LEN_WIDTH-1:0]   status_chunks_done
);
  localparam int TW1 = TAG_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE, S_ABORTED} state_t;

  state_t                 state_q, state_d;
  logic                   abort_q;
  logic [LEN_WIDTH-1:0]   num_q, issued_q, retire_cnt;
  logic [ADDR_WIDTH-1:0]  next_addr_q;
  logic [TAG_W-1:0]       rr_q, grant_idx, rr_nxt;
  logic [TW1-1:0]         idx_w;
  logic                   any_free, start_ok, load;
  logic [NUM_ENGINES-1:0] busy, retire, spurious, grant_oh;

  assign start_ok    = cfg_start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ABORTED);
  assign status_busy = (state_q == S_DISPATCH) || (state_q == S_DRAIN);

  // An abort in the same cycle blocks the load, so nothing new issues once abort is seen.
  assign load = (state_q == S_DISPATCH) && !cfg_abort && (!fetch_req_valid || fetch_req_ready) &&
                (issued_q < num_q) && any_free;

  // Round-robin search: first free engine at or after the pointer, wrapping at NUM_ENGINES.
  always_comb begin
    any_free  = 1'b0;
    grant_idx = '0;
    idx_w     = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      idx_w = {1'b0, rr_q} + TW1'(i);
      if (idx_w >= TW1'(NUM_ENGINES)) idx_w = idx_w - TW1'(NUM_ENGINES);
      if (!any_free && !busy[idx_w[TAG_W-1:0]]) begin
        any_free  = 1'b1;
        grant_idx = idx_w[TAG_W-1:0];
      end
    end
  end

  assign rr_nxt = (grant_idx == TAG_W'(NUM_ENGINES - 1)) ? '0 : grant_idx + TAG_W'(1);

  // One-hot reserve for the granted engine, and a count of engines retiring this cycle.
  always_comb begin
    grant_oh   = '0;
    retire_cnt = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      grant_oh[i] = load && (grant_idx == TAG_W'(i));
      retire_cnt  = retire_cnt + LEN_WIDTH'(retire[i]);
    end
  end

  gss_engine_slot u_slot [NUM_ENGINES-1:0] (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .reserve  (grant_oh),
    .done     (eng_done),
    .busy     (busy),
    .retire   (retire),
    .spurious (spurious)
  );

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. Drain waits for every reserved engine, including a held request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ABORTED: if (start_ok) state_d = S_DISPATCH;
      S_DISPATCH: begin
        if (cfg_abort)                                   state_d = S_DRAIN;
        else if (issued_q == num_q && !fetch_req_valid)  state_d = S_DRAIN;
      end
      S_DRAIN: if (busy == '0 && !fetch_req_valid)       state_d = abort_q ? S_ABORTED : S_DONE;
      default:                                           state_d = S_IDLE;
    endcase
  end

  // Request register: holds address and tag stable until the reader accepts them.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      fetch_req_valid <= 1'b0;
      fetch_req_addr  <= '0;
      fetch_req_tag   <= '0;
    end else if (load) begin
      fetch_req_valid <= 1'b1;
      fetch_req_addr  <= next_addr_q;
      fetch_req_tag   <= grant_idx;
    end else if (fetch_req_ready) begin
      fetch_req_valid <= 1'b0;
    end
  end

  // Run context, issue bookkeeping and sticky status. An accepted start clears everything except the RR pointer.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      num_q              <= '0;
      issued_q           <= '0;
      next_addr_q        <= '0;
      rr_q               <= '0;
      abort_q            <= 1'b0;
      status_done        <= 1'b0;
      status_aborted     <= 1'b0;
      status_error       <= 1'b0;
      status_chunks_done <= '0;
    end else if (start_ok) begin
      num_q              <= cfg_num_chunks;
      issued_q           <= '0;
      next_addr_q        <= cfg_base_addr;
      abort_q            <= 1'b0;
      status_done        <= 1'b0;
      status_aborted     <= 1'b0;
      status_error       <= 1'b0;
      status_chunks_done <= '0;
    end else begin
      if (load) begin
        issued_q    <= issued_q + LEN_WIDTH'(1);
        next_addr_q <= next_addr_q + ADDR_WIDTH'(CHUNK_BYTES);
        rr_q        <= rr_nxt;
      end
      if (state_q == S_DISPATCH && cfg_abort)        abort_q        <= 1'b1;
      if (state_q == S_DRAIN && state_d == S_DONE)    status_done    <= 1'b1;
      if (state_q == S_DRAIN && state_d == S_ABORTED) status_aborted <= 1'b1;
      if (|spurious)                                  status_error   <= 1'b1;
      status_chunks_done <= status_chunks_done + retire_cnt;
    end
  end
endmodule

// File: tb/tb_genome_search_scheduler.sv
// Directed bench for genome_search_scheduler: reset, empty run, full run,
// backpressure, simultaneous completion, abort, spurious done and mid-run reset.
module tb_genome_search_scheduler;
  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [31:0] cfg_base_addr = '0, cfg_num_chunks = '0;
  logic        fetch_req_valid, fetch_req_ready = 1'b0;
  logic [31:0] fetch_req_addr;
  logic [1:0]  fetch_req_tag;
  logic [3:0]  eng_done, eng_auto = '0, eng_man = '0;
  logic        status_busy, status_done, status_aborted, status_error;
  logic [31:0] status_chunks_done;

  int n_cmp = 0, n_err = 0;
  logic auto_en = 1'b0;
  int eng_lat = 10;
  int cnt [4];
  int acc_total = 0;
  logic [31:0] acc_addr [256];
  logic [1:0]  acc_tag  [256];

  assign eng_done = eng_auto | eng_man;

  genome_search_scheduler dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_base_addr(cfg_base_addr), .cfg_num_chunks(cfg_num_chunks),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_req_addr(fetch_req_addr), .fetch_req_tag(fetch_req_tag), .eng_done(eng_done),
    .status_busy(status_busy), .status_done(status_done), .status_aborted(status_aborted),
    .status_error(status_error), .status_chunks_done(status_chunks_done)
  );

  always #5 ACLK = ~ACLK;

  // Engine model and acceptance log: each accepted chunk finishes eng_lat cycles later.
  always @(negedge ACLK) begin
    eng_auto = '0;
    if (ARESET) begin
      for (int k = 0; k < 4; k++) cnt[k] = 0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (cnt[k] != 0) begin
          cnt[k]--;
          if (cnt[k] == 0) eng_auto[k] = 1'b1;
        end
      if (fetch_req_valid && fetch_req_ready) begin
        acc_addr[acc_total % 256] = fetch_req_addr;
        acc_tag[acc_total % 256]  = fetch_req_tag;
        acc_total++;
        if (auto_en) cnt[fetch_req_tag] = eng_lat;
      end
    end
  end

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic do_reset();
    ARESET = 1'b1; cfg_start = 0; cfg_abort = 0; eng_man = '0; fetch_req_ready = 0; auto_en = 0;
    tick(); tick();
    ARESET = 1'b0;
  endtask

  task automatic start_run(input logic [31:0] base, input logic [31:0] num);
    cfg_base_addr = base; cfg_num_chunks = num; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({fetch_req_valid, fetch_req_addr, fetch_req_tag, status_busy, status_done, status_aborted,
         status_error, status_chunks_done} !== '0) begin
      n_err++; $display("FAIL reset_outputs: valid=%b addr=%h tag=%0d busy=%b done=%b ab=%b err=%b cnt=%0d want all 0",
        fetch_req_valid, fetch_req_addr, fetch_req_tag, status_busy, status_done, status_aborted,
        status_error, status_chunks_done);
    end
    ARESET = 1'b0;
  endtask

  task automatic test_zero_chunks();
    int a0;
    logic saw_valid;
    do_reset();
    fetch_req_ready = 1'b1;
    a0 = acc_total; saw_valid = 0;
    start_run(32'h2000, 0);
    for (int c = 1; c <= 3; c++) begin
      if (fetch_req_valid) saw_valid = 1;
      n_cmp++;
      if (status_done !== (c == 3)) begin
        n_err++; $display("FAIL zero_done_c%0d: got %b want %b", c, status_done, (c == 3));
      end
      if (c < 3) tick();
    end
    n_cmp++;
    if (saw_valid || acc_total != a0 || status_chunks_done !== 0) begin
      n_err++; $display("FAIL zero_no_req: valid_seen=%b acc=%0d cnt=%0d want 0/0/0", saw_valid, acc_total - a0, status_chunks_done);
    end
  endtask

  task automatic test_full_run();
    int a0;
    logic [31:0] exp_addr [6] = '{32'h1000, 32'h1040, 32'h1080, 32'h10C0, 32'h1100, 32'h1140};
    logic [1:0]  exp_tag  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int waited;
    do_reset();
    auto_en = 1; eng_lat = 10; fetch_req_ready = 1'b1;
    a0 = acc_total;
    start_run(32'h1000, 6);
    n_cmp++;
    if (fetch_req_valid !== 1'b0 || status_busy !== 1'b1) begin
      n_err++; $display("FAIL run_first_cycle: valid=%b busy=%b want 0/1", fetch_req_valid, status_busy);
    end
    tick();
    n_cmp++;
    if (fetch_req_valid !== 1'b1 || fetch_req_addr !== 32'h1000 || fetch_req_tag !== 2'd0) begin
      n_err++; $display("FAIL run_first_req: valid=%b addr=%h tag=%0d want 1/1000/0", fetch_req_valid, fetch_req_addr, fetch_req_tag);
    end
    waited = 0;
    while (!status_done && waited < 200) begin tick(); waited++; end
    n_cmp++;
    if (!status_done) begin
      n_err++; $display("FAIL run_timeout: done=%b after %0d cycles want 1", status_done, waited);
    end
    n_cmp++;
    if (acc_total - a0 !== 6) begin
      n_err++; $display("FAIL run_req_count: got %0d want 6", acc_total - a0);
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (acc_addr[(a0 + i) % 256] !== exp_addr[i] || acc_tag[(a0 + i) % 256] !== exp_tag[i]) begin
        n_err++; $display("FAIL run_req%0d: addr=%h tag=%0d want %h/%0d", i, acc_addr[(a0 + i) % 256],
          acc_tag[(a0 + i) % 256], exp_addr[i], exp_tag[i]);
      end
    end
    n_cmp++;
    if (status_chunks_done !== 6 || status_busy !== 0 || status_aborted !== 0 || status_error !== 0) begin
      n_err++; $display("FAIL run_status: cnt=%0d busy=%b ab=%b err=%b want 6/0/0/0", status_chunks_done, status_busy, status_aborted, status_error);
    end
  endtask

  task automatic test_backpressure();
    int a0;
    logic [31:0] h_addr;
    logic [1:0]  h_tag;
    do_reset();
    auto_en = 1; fetch_req_ready = 1'b0;
    a0 = acc_total;
    start_run(32'h3000, 2);
    tick();
    h_addr = fetch_req_addr; h_tag = fetch_req_tag;
    n_cmp++;
    if (fetch_req_valid !== 1'b1 || h_addr !== 32'h3000 || h_tag !== 2'd0) begin
      n_err++; $display("FAIL bp_initial: valid=%b addr=%h tag=%0d want 1/3000/0", fetch_req_valid, h_addr, h_tag);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (fetch_req_valid !== 1'b1 || fetch_req_addr !== 32'h3000 || fetch_req_tag !== 2'd0) begin
        n_err++; $display("FAIL bp_hold_c%0d: valid=%b addr=%h tag=%0d want 1/3000/0", c, fetch_req_valid, fetch_req_addr, fetch_req_tag);
      end
    end
    fetch_req_ready = 1'b1;
    tick();
    fetch_req_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if (acc_total - a0 !== 1 || fetch_req_valid !== 1'b1 || fetch_req_addr !== 32'h3040 || fetch_req_tag !== 2'd1) begin
      n_err++; $display("FAIL bp_release: acc=%0d valid=%b addr=%h tag=%0d want 1/1/3040/1", acc_total - a0, fetch_req_valid, fetch_req_addr, fetch_req_tag);
    end
  endtask

  task automatic test_multi_done();
    do_reset();
    fetch_req_ready = 1'b1;
    start_run(32'h0, 8);
    for (int c = 0; c < 7; c++) tick();
    n_cmp++;
    if (fetch_req_valid !== 1'b0 || status_chunks_done !== 0) begin
      n_err++; $display("FAIL md_all_busy: valid=%b cnt=%0d want 0/0", fetch_req_valid, status_chunks_done);
    end
    eng_man = 4'b0101;
    tick();
    eng_man = '0;
    n_cmp++;
    if (status_chunks_done !== 2 || fetch_req_valid !== 1'b0) begin
      n_err++; $display("FAIL md_count: cnt=%0d valid=%b want 2/0", status_chunks_done, fetch_req_valid);
    end
    tick();
    n_cmp++;
    if (fetch_req_valid !== 1'b1 || fetch_req_tag !== 2'd0 || fetch_req_addr !== 32'h100) begin
      n_err++; $display("FAIL md_regrant0: valid=%b tag=%0d addr=%h want 1/0/100", fetch_req_valid, fetch_req_tag, fetch_req_addr);
    end
    tick();
    n_cmp++;
    if (fetch_req_valid !== 1'b1 || fetch_req_tag !== 2'd2 || fetch_req_addr !== 32'h140) begin
      n_err++; $display("FAIL md_regrant2: valid=%b tag=%0d addr=%h want 1/2/140", fetch_req_valid, fetch_req_tag, fetch_req_addr);
    end
  endtask

  task automatic test_abort();
    int a0, waited;
    logic late_valid;
    do_reset();
    auto_en = 1; eng_lat = 10; fetch_req_ready = 1'b1;
    a0 = acc_total;
    start_run(32'h4000, 20);
    waited = 0;
    while (!(fetch_req_valid && fetch_req_ready && acc_total - a0 == 2) && waited < 20) begin tick(); waited++; end
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    n_cmp++;
    if (fetch_req_valid !== 1'b0 || status_busy !== 1'b1) begin
      n_err++; $display("FAIL abort_stop: valid=%b busy=%b want 0/1", fetch_req_valid, status_busy);
    end
    late_valid = 0; waited = 0;
    while (status_busy && waited < 100) begin
      if (fetch_req_valid) late_valid = 1;
      tick(); waited++;
    end
    n_cmp++;
    if (status_busy || late_valid || acc_total - a0 !== 3) begin
      n_err++; $display("FAIL abort_drain: busy=%b late_valid=%b acc=%0d want 0/0/3", status_busy, late_valid, acc_total - a0);
    end
    n_cmp++;
    if (status_aborted !== 1'b1 || status_done !== 1'b0 || status_chunks_done !== 3) begin
      n_err++; $display("FAIL abort_status: ab=%b done=%b cnt=%0d want 1/0/3", status_aborted, status_done, status_chunks_done);
    end
  endtask

  task automatic test_error_and_reset();
    int waited;
    do_reset();
    fetch_req_ready = 1'b1;
    start_run(32'h0, 2);
    for (int c = 0; c < 6; c++) tick();
    eng_man = 4'b1000;
    tick();
    eng_man = '0;
    n_cmp++;
    if (status_error !== 1'b1 || status_chunks_done !== 0 || status_busy !== 1'b1) begin
      n_err++; $display("FAIL err_spurious: err=%b cnt=%0d busy=%b want 1/0/1", status_error, status_chunks_done, status_busy);
    end
    start_run(32'h8000, 9);
    tick();
    n_cmp++;
    if (status_error !== 1'b1 || status_busy !== 1'b1 || fetch_req_valid !== 1'b0) begin
      n_err++; $display("FAIL err_start_ignored: err=%b busy=%b valid=%b want 1/1/0", status_error, status_busy, fetch_req_valid);
    end
    eng_man = 4'b0011;
    tick();
    eng_man = '0;
    waited = 0;
    while (!status_done && waited < 10) begin tick(); waited++; end
    n_cmp++;
    if (status_done !== 1'b1 || status_chunks_done !== 2 || status_error !== 1'b1) begin
      n_err++; $display("FAIL err_finish: done=%b cnt=%0d err=%b want 1/2/1", status_done, status_chunks_done, status_error);
    end
    eng_lat = 10; auto_en = 1;
    start_run(32'h5000, 5);
    tick(); tick(); tick();
    ARESET = 1'b1;
    tick();
    n_cmp++;
    if ({fetch_req_valid, fetch_req_addr, fetch_req_tag, status_busy, status_done, status_aborted,
         status_error, status_chunks_done} !== '0) begin
      n_err++; $display("FAIL midrun_reset: valid=%b addr=%h tag=%0d busy=%b done=%b ab=%b err=%b cnt=%0d want all 0",
        fetch_req_valid, fetch_req_addr, fetch_req_tag, status_busy, status_done, status_aborted,
        status_error, status_chunks_done);
    end
    ARESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_chunks();
    test_full_run();
    test_backpressure();
    test_multi_done();
    test_abort();
    test_error_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
